// File: rtl/minsoc_clkrst_gen.sv
// Reset sequencer plus per-channel clock-enable/divided-clock generators.
// All outputs registered or decoded from registered state; no backpressure (free-running).
module minsoc_clkrst_gen #(
  parameter int          NUM_CH      = 2,
  parameter int          DIV_WIDTH   = 8,
  parameter int unsigned DIV_INIT    = 1,
  parameter int          RST_HOLD    = 16,
  parameter logic        RESET_LEVEL = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sw_rst,
  input  logic                 div_we,
  input  logic [1:0]           div_sel,
  input  logic [DIV_WIDTH-1:0] div_val,
  output logic                 rst_out,
  output logic                 locked,
  output logic [NUM_CH-1:0]    ch_en,
  output logic [NUM_CH-1:0]    ch_clk
);

  localparam int HW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_END = HW'(RST_HOLD);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_INIT);

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

  state_t        state, next_state;
  logic [HW-1:0] hold_cnt;
  logic          ch_active;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= HOLD;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      HOLD:    if (hold_cnt == HOLD_END) next_state = RUN;
      RUN:     if (sw_rst) next_state = HOLD;
      default: next_state = HOLD;
    endcase
  end

  always_comb begin
    rst_out = RESET_LEVEL;
    locked  = 1'b0;
    if (state == RUN) begin
      rst_out = ~RESET_LEVEL;
      locked  = 1'b1;
    end
  end

  // Held at zero throughout RUN so a soft reset always restarts a full hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    hold_cnt <= '0;
    else if (state == RUN)        hold_cnt <= '0;
    else if (hold_cnt != HOLD_END) hold_cnt <= hold_cnt + 1'b1;
  end

  // Channels only count on edges that stay in RUN, so they are idle in every HOLD cycle.
  assign ch_active = (state == RUN) && (next_state == RUN);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 en_q;
    logic                 clk_q;
    logic                 wr;

    // Out-of-range selects never match any instantiated channel.
    assign wr = div_we && (div_sel == 2'(c));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        div_q <= DIV_RST;
        cnt_q <= '0;
        en_q  <= 1'b0;
        clk_q <= 1'b0;
      end else begin
        if (wr) div_q <= div_val;
        if (!ch_active) begin
          cnt_q <= '0;
          en_q  <= 1'b0;
          clk_q <= 1'b0;
        end else if (wr) begin
          cnt_q <= '0;
          en_q  <= 1'b0;
        end else if (cnt_q == div_q) begin
          cnt_q <= '0;
          en_q  <= 1'b1;
          clk_q <= ~clk_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          en_q  <= 1'b0;
        end
      end
    end

    assign ch_en[c]  = en_q;
    assign ch_clk[c] = clk_q;
  end

endmodule

// File: tb/tb_minsoc_clkrst_gen.sv
// Directed bench for minsoc_clkrst_gen with default parameters.
module tb_minsoc_clkrst_gen;

  logic       clock;
  logic       reset;
  logic       sw_rst;
  logic       div_we;
  logic [1:0] div_sel;
  logic [7:0] div_val;
  logic       rst_out;
  logic       locked;
  logic [1:0] ch_en;
  logic [1:0] ch_clk;

  int errors = 0;
  int checks = 0;

  minsoc_clkrst_gen dut (
    .clock   (clock),
    .reset   (reset),
    .sw_rst  (sw_rst),
    .div_we  (div_we),
    .div_sel (div_sel),
    .div_val (div_val),
    .rst_out (rst_out),
    .locked  (locked),
    .ch_en   (ch_en),
    .ch_clk  (ch_clk)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Observation vector: {rst_out, locked, ch_en[1:0], ch_clk[1:0]}
  logic [5:0] obs;
  assign obs = {rst_out, locked, ch_en, ch_clk};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    #12;
    checks++;
    if (obs !== 6'b10_00_00) begin
      errors++;
      $display("FAIL reset_state obs=%b exp=%b", obs, 6'b10_00_00);
    end
    reset = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp = (k <= 16) ? 6'b10_00_00 : 6'b01_00_00;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL hold_release edge=%0d obs=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  // Both channels at divisor 1: enable every 2 cycles, clock period 4, in phase.
  task automatic test_div_init();
    logic [1:0] en, ck;
    for (int i = 1; i <= 8; i++) begin
      tick();
      en = (i % 2 == 0) ? 2'b11 : 2'b00;
      ck = ((i / 2) % 2 == 1) ? 2'b11 : 2'b00;
      checks++;
      if (obs !== {2'b01, en, ck}) begin
        errors++;
        $display("FAIL div_init cyc=%0d obs=%b exp=%b", i, obs, {2'b01, en, ck});
      end
    end
  endtask

  task automatic test_write_div0();
    logic en0, ck0, en1, ck1;
    div_we = 1'b1; div_sel = 2'd1; div_val = 8'd0;
    for (int i = 9; i <= 16; i++) begin
      tick();
      div_we = 1'b0;
      en0 = (i % 2 == 0);
      ck0 = ((i / 2) % 2 == 1);
      en1 = (i >= 10);
      ck1 = (i >= 10) && ((i - 10) % 2 == 0);
      checks++;
      if (obs !== {2'b01, en1, en0, ck1, ck0}) begin
        errors++;
        $display("FAIL write_div0 cyc=%0d obs=%b exp=%b", i, obs, {2'b01, en1, en0, ck1, ck0});
      end
    end
  endtask

  task automatic test_sw_rst();
    logic en0, ck0, ck1;
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin
        if (k == 5) sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
      end
      checks++;
      if (obs !== 6'b10_00_00) begin
        errors++;
        $display("FAIL sw_rst_hold k=%0d obs=%b exp=%b", k, obs, 6'b10_00_00);
      end
    end
    for (int j = 0; j <= 6; j++) begin
      tick();
      en0 = (j > 0) && (j % 2 == 0);
      ck0 = ((j / 2) % 2 == 1);
      ck1 = (j % 2 == 1);
      checks++;
      if (obs !== {2'b01, (j > 0), en0, ck1, ck0}) begin
        errors++;
        $display("FAIL sw_rst_resume j=%0d obs=%b exp=%b", j, obs, {2'b01, (j > 0), en0, ck1, ck0});
      end
    end
  endtask

  task automatic test_bad_sel_and_tc();
    logic en0, ck0, ck1;
    logic [5:0] tc_exp [3];
    div_we = 1'b1; div_sel = 2'd3; div_val = 8'd5;
    for (int j = 7; j <= 11; j++) begin
      tick();
      div_we = 1'b0;
      en0 = (j % 2 == 0);
      ck0 = ((j / 2) % 2 == 1);
      ck1 = (j % 2 == 1);
      checks++;
      if (obs !== {2'b01, 1'b1, en0, ck1, ck0}) begin
        errors++;
        $display("FAIL bad_sel j=%0d obs=%b exp=%b", j, obs, {2'b01, 1'b1, en0, ck1, ck0});
      end
    end
    // Write lands on channel 0's terminal-count edge: pulse and toggle suppressed.
    tc_exp[0] = 6'b01_10_01;
    tc_exp[1] = 6'b01_10_11;
    tc_exp[2] = 6'b01_11_00;
    div_we = 1'b1; div_sel = 2'd0; div_val = 8'd1;
    for (int j = 0; j < 3; j++) begin
      tick();
      div_we = 1'b0;
      checks++;
      if (obs !== tc_exp[j]) begin
        errors++;
        $display("FAIL write_at_tc j=%0d obs=%b exp=%b", 12 + j, obs, tc_exp[j]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic en1, ck0, ck1;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 6'b10_00_00) begin
      errors++;
      $display("FAIL async_reset obs=%b exp=%b", obs, 6'b10_00_00);
    end
    #2;
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        div_we = 1'b1; div_sel = 2'd0; div_val = 8'd0;
      end
      tick();
      div_we = 1'b0;
      checks++;
      if (obs !== 6'b10_00_00) begin
        errors++;
        $display("FAIL async_rehold k=%0d obs=%b exp=%b", k, obs, 6'b10_00_00);
      end
    end
    // Channel 0 now runs at the divisor written in HOLD; channel 1 is back at its reset divisor.
    for (int j = 0; j <= 5; j++) begin
      tick();
      en1 = (j > 0) && (j % 2 == 0);
      ck1 = ((j / 2) % 2 == 1);
      ck0 = (j % 2 == 1);
      checks++;
      if (obs !== {2'b01, en1, (j > 0), ck1, ck0}) begin
        errors++;
        $display("FAIL async_resume j=%0d obs=%b exp=%b", j, obs, {2'b01, en1, (j > 0), ck1, ck0});
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    sw_rst  = 1'b0;
    div_we  = 1'b0;
    div_sel = 2'd0;
    div_val = 8'd0;
    test_reset();
    test_div_init();
    test_write_div0();
    test_sw_rst();
    test_bad_sel_and_tc();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
